tx_buffer: RTL and testbench

Transmit-side message buffer for the UART component, the counterpart of the receive buffer. The host loads up to DEPTH bytes by address, then issues `start` with a length. The block streams the bytes in order, index 0 first, to the UART transmitter using a `tx_start`/`tx_done` handshake. It reports `busy` while sending and pulses `done` when the last byte has been acknowledged.

---
 rtl/tx_buffer.sv | 109 ++++++++++
 tb/tb_tx_buffer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/tx_buffer.sv
// Purpose : UART transmit message buffer. The host loads bytes by address, then
//           issues start/len. Bytes are streamed from index 0 over tx_start/tx_done.
// Latency : tx_start for byte 0 is one cycle after start is accepted. The next
//           tx_start follows one cycle after tx_done. done follows one cycle after
//           the last tx_done.
// Backpr. : stalls indefinitely in WAIT until the transmitter returns tx_done.
//           Writes and start are ignored while busy.
// Ports   : clk, rst_n (async, active low); wr/address/w_data write a slot;
//           start/len begin a send; tx_done acknowledges a byte;
//           tx_data/tx_start feed the transmitter; busy/done report status.
module tx_buffer #(
  parameter int DEPTH  = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [2:0]        address,
  input  logic [DATA_W-1:0] w_data,
  input  logic              start,
  input  logic [2:0]        len,
  input  logic              tx_done,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] DEPTH_L = 3'(DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, FIN} state_t;

  state_t            state, state_nxt;
  logic [2:0]        idx, idx_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic              load;
  logic [DATA_W-1:0] load_dat;
  logic              wr_en;

  logic [DATA_W-1:0] mem [DEPTH];

  // The message is frozen while busy.
  assign wr_en = wr && (address < DEPTH_L) && !busy;

  // Message storage has no reset; software rewrites it before each send.
  always_ff @(posedge clk) begin
    if (wr_en) mem[address] <= w_data;
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start && (len != 3'd0)) begin
          cnt_nxt   = (len > DEPTH_L) ? DEPTH_L : len;
          idx_nxt   = 3'd0;
          load      = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: state_nxt = WAIT;
      WAIT: begin
        if (tx_done) begin
          if (idx == cnt - 3'd1) begin
            state_nxt = FIN;
          end else begin
            idx_nxt   = idx + 3'd1;
            load      = 1'b1;
            state_nxt = SEND;
          end
        end
      end
      FIN: begin
        idx_nxt   = 3'd0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A write landing on the same edge as an accepted start must be what
    // goes out, so bypass the array when it targets the slot being loaded.
    load_dat = (wr_en && (address == idx_nxt)) ? w_data : mem[idx_nxt];
  end

  // Outputs are flops decoded from the next state, so they switch cleanly
  // and drop to zero immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= 3'd0;
      cnt      <= 3'd0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      cnt      <= cnt_nxt;
      if (load) tx_data <= load_dat;
      tx_start <= (state_nxt == SEND);
      busy     <= (state_nxt == SEND) || (state_nxt == WAIT);
      done     <= (state_nxt == FIN);
    end
  end

endmodule

// File: tb/tb_tx_buffer.sv
// Purpose : bench for tx_buffer, with cycle-exact vectors plus transmitter-driven sequences.
// Latency : outputs are sampled 1 time unit after each rising edge.
// Ports   : none; generates clk and drives every tx_buffer port.
module tb_tx_buffer;

  logic       clk = 1'b0;
  logic       rst_n, wr, start, tx_done;
  logic [2:0] address, len;
  logic [7:0] w_data, tx_data;
  logic       tx_start, busy, done;

  always #5 clk = ~clk;

  tx_buffer #(.DEPTH(5), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .address(address), .w_data(w_data),
    .start(start), .len(len), .tx_done(tx_done), .tx_data(tx_data),
    .tx_start(tx_start), .busy(busy), .done(done)
  );

  typedef struct {
    logic       wr;
    logic [2:0] address;
    logic [7:0] w_data;
    logic       start;
    logic [2:0] len;
    logic       tx_done;
    logic [7:0] e_data;
    logic       e_start;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t       vecs[16];
  int         nvec = 0;
  int         nerr = 0;
  logic [7:0] got_q[$];
  logic [39:0] msg = {8'h21, 8'h41, 8'h4C, 8'h4F, 8'h48};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_bytes(input string name, input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = (got_q.size() > i) ? got_q[i] : 8'hxx;
      chk($sformatf("%s_byte%0d", name, i), {24'd0, b}, {24'd0, msg[i*8 +: 8]});
    end
  endtask

  task automatic wr_byte(input logic [2:0] a, input logic [7:0] d);
    wr = 1'b1; address = a; w_data = d;
    tick();
    wr = 1'b0;
  endtask

  // Starts a send and plays the transmitter: tx_done follows each tx_start
  // by dly cycles. With disturb set, tx_done is also raised alongside every
  // tx_start, and a write to slot 3 plus a start are injected during WAIT.
  task automatic run_tx(input logic [2:0] l, input int dly, input bit disturb,
                        output int nstart, output int ndone, output bit first_ok,
                        output bit busy_ok, output bit stable_ok);
    int cd;
    logic [7:0] held;
    got_q.delete();
    start = 1'b1; len = l;
    tick();
    start = 1'b0; len = 3'd0;
    nstart = 0; ndone = 0; first_ok = tx_start; busy_ok = 1'b1; stable_ok = 1'b1;
    cd = 0; held = tx_data;
    for (int c = 0; c < 600 && ndone == 0; c++) begin
      wr = 1'b0; start = 1'b0; tx_done = 1'b0;
      if (tx_start) begin
        got_q.push_back(tx_data);
        nstart++;
        held = tx_data;
        cd = dly;
        if (disturb) tx_done = 1'b1;
      end else begin
        if (busy && tx_data !== held) stable_ok = 1'b0;
        if (cd > 0) begin
          cd--;
          if (cd == 0) tx_done = 1'b1;
        end
      end
      if (done) begin
        ndone++;
        if (busy) busy_ok = 1'b0;
      end else if (!busy) begin
        busy_ok = 1'b0;
      end
      if (disturb && c == 3) begin
        wr = 1'b1; address = 3'd3; w_data = 8'hFF; start = 1'b1; len = 3'd2;
      end
      tick();
    end
    wr = 1'b0; start = 1'b0; len = 3'd0; tx_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  ns, nd, n, cd;
    bit  f_ok, b_ok, s_ok, saw;

    //            wr a     data   st len  txd  e_data e_st e_bsy e_dn
    vecs[0]  = '{1, 3'd0, 8'h48, 0, 3'd0, 0, 8'h00, 0, 0, 0};
    vecs[1]  = '{1, 3'd1, 8'h4F, 0, 3'd0, 0, 8'h00, 0, 0, 0};
    vecs[2]  = '{1, 3'd2, 8'h4C, 0, 3'd0, 0, 8'h00, 0, 0, 0};
    vecs[3]  = '{1, 3'd3, 8'h41, 0, 3'd0, 0, 8'h00, 0, 0, 0};
    vecs[4]  = '{1, 3'd4, 8'h21, 0, 3'd0, 0, 8'h00, 0, 0, 0};
    vecs[5]  = '{1, 3'd6, 8'hEE, 0, 3'd0, 0, 8'h00, 0, 0, 0}; // out of range
    vecs[6]  = '{0, 3'd0, 8'h00, 0, 3'd0, 1, 8'h00, 0, 0, 0}; // tx_done in IDLE
    vecs[7]  = '{0, 3'd0, 8'h00, 1, 3'd0, 0, 8'h00, 0, 0, 0}; // len 0
    vecs[8]  = '{0, 3'd0, 8'h00, 0, 3'd0, 0, 8'h00, 0, 0, 0};
    vecs[9]  = '{1, 3'd0, 8'h5A, 1, 3'd2, 0, 8'h5A, 1, 1, 0}; // write + start
    vecs[10] = '{0, 3'd0, 8'h00, 0, 3'd0, 1, 8'h5A, 0, 1, 0}; // tx_done in SEND
    vecs[11] = '{0, 3'd0, 8'h00, 0, 3'd0, 1, 8'h4F, 1, 1, 0};
    vecs[12] = '{0, 3'd0, 8'h00, 0, 3'd0, 0, 8'h4F, 0, 1, 0};
    vecs[13] = '{0, 3'd0, 8'h00, 0, 3'd0, 1, 8'h4F, 0, 0, 1}; // last byte
    vecs[14] = '{0, 3'd0, 8'h00, 0, 3'd0, 0, 8'h4F, 0, 0, 0};
    vecs[15] = '{1, 3'd0, 8'h48, 0, 3'd0, 0, 8'h4F, 0, 0, 0};

    rst_n = 1'b0; wr = 1'b0; address = 3'd0; w_data = 8'h00;
    start = 1'b0; len = 3'd0; tx_done = 1'b0;
    #1;
    chk("reset_outputs", {21'd0, tx_data, tx_start, busy, done}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) begin
      wr = vecs[i].wr; address = vecs[i].address; w_data = vecs[i].w_data;
      start = vecs[i].start; len = vecs[i].len; tx_done = vecs[i].tx_done;
      tick();
      chk($sformatf("vec%0d", i), {21'd0, tx_data, tx_start, busy, done},
          {21'd0, vecs[i].e_data, vecs[i].e_start, vecs[i].e_busy, vecs[i].e_done});
    end
    wr = 1'b0; start = 1'b0; len = 3'd0; tx_done = 1'b0;

    // Full five-byte message, tx_done 10 cycles after each tx_start.
    run_tx(3'd5, 10, 1'b0, ns, nd, f_ok, b_ok, s_ok);
    chk("normal_nstart", ns, 5);
    chk("normal_ndone", nd, 1);
    chk("normal_busy", {31'd0, b_ok}, 1);
    chk("normal_stable", {31'd0, s_ok}, 1);
    check_bytes("normal", 5);

    // Back-to-back, len 7 clamped to 5, with writes/start/early tx_done injected.
    run_tx(3'd7, 3, 1'b1, ns, nd, f_ok, b_ok, s_ok);
    chk("b2b_first_start", {31'd0, f_ok}, 1);
    chk("clamp_nstart", ns, 5);
    chk("clamp_ndone", nd, 1);
    chk("clamp_stable", {31'd0, s_ok}, 1);
    check_bytes("clamp", 5);

    // Short message, again started the cycle after done.
    run_tx(3'd2, 2, 1'b0, ns, nd, f_ok, b_ok, s_ok);
    chk("short_first_start", {31'd0, f_ok}, 1);
    chk("short_nstart", ns, 2);
    chk("short_ndone", nd, 1);
    check_bytes("short", 2);

    // Reset while byte 3 of 5 is outstanding.
    start = 1'b1; len = 3'd5;
    tick();
    start = 1'b0; len = 3'd0;
    n = 0; cd = 0; saw = 1'b0;
    for (int c = 0; c < 300 && n < 3; c++) begin
      tx_done = 1'b0;
      if (tx_start) begin
        n++;
        cd = 4;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) tx_done = 1'b1;
      end
      if (done) saw = 1'b1;
      tick();
    end
    tx_done = 1'b0;
    chk("rst_reach_byte3", n, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", {21'd0, tx_data, tx_start, busy, done}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      if (done || tx_start || busy) saw = 1'b1;
    end
    #2 rst_n = 1'b1;
    tick();
    if (done || tx_start || busy) saw = 1'b1;
    chk("rst_no_done", {31'd0, saw}, 0);
    wr_byte(3'd0, 8'h48);
    wr_byte(3'd1, 8'h4F);
    wr_byte(3'd2, 8'h4C);
    wr_byte(3'd3, 8'h41);
    wr_byte(3'd4, 8'h21);
    run_tx(3'd5, 2, 1'b0, ns, nd, f_ok, b_ok, s_ok);
    chk("after_rst_nstart", ns, 5);
    chk("after_rst_ndone", nd, 1);
    check_bytes("after_rst", 5);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
